// File: rtl/demux_4_1_2_reg.sv
// Registered 1-to-2 demultiplexer: one valid/ready input steered to two holding slots (A, B).
// Optional per-output delivery counters are enabled by defining DEMUX_CNT_EN.
module demux_4_1_2_reg #(
  parameter int WIDTH = 4
`ifdef DEMUX_CNT_EN
  ,
  parameter int CNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
`endif
);

  // Slot 0 is output A, slot 1 is output B.
  logic [1:0]       slot_ready;
  logic [1:0]       slot_open;
  logic [1:0]       slot_fire;
  logic [1:0]       slot_valid_q;
  logic [WIDTH-1:0] slot_data_q [2];
  logic             in_fire;

  assign slot_ready = {b_ready, a_ready};
  assign slot_open  = ~slot_valid_q | slot_ready;
  assign slot_fire  = slot_valid_q & slot_ready;

  // Only the selected slot gates acceptance, so a stalled word blocks the other output too.
  assign in_ready = slot_open[in_sel];
  assign in_fire  = in_valid & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      logic             load;
      logic             valid_d;
      logic [WIDTH-1:0] data_d;

      assign load = in_fire & (in_sel == 1'(gi)) & ~flush;

      always_comb begin
        valid_d = slot_valid_q[gi];
        data_d  = slot_data_q[gi];
        if (flush) begin
          valid_d = 1'b0;
        end else if (load) begin
          valid_d = 1'b1;
          data_d  = in_data;
        end else if (slot_fire[gi]) begin
          valid_d = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_valid_q[gi] <= 1'b0;
          slot_data_q[gi]  <= '0;
        end else begin
          slot_valid_q[gi] <= valid_d;
          slot_data_q[gi]  <= data_d;
        end
      end
    end
  endgenerate

  assign a_valid = slot_valid_q[0];
  assign a_data  = slot_data_q[0];
  assign b_valid = slot_valid_q[1];
  assign b_data  = slot_data_q[1];

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt_q [2];

  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_d;

      // Counts deliveries, so flush leaves it alone; wraps naturally at all-ones.
      assign cnt_d = slot_fire[gi] ? cnt_q[gi] + 1'b1 : cnt_q[gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q[gi] <= '0;
        end else begin
          cnt_q[gi] <= cnt_d;
        end
      end
    end
  endgenerate

  assign cnt_a = cnt_q[0];
  assign cnt_b = cnt_q[1];
`endif

endmodule

// File: tb/tb_demux_4_1_2_reg.sv
// Directed bench for demux_4_1_2_reg: routing, backpressure, head-of-line stall, flush, async reset.
module tb_demux_4_1_2_reg;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [3:0] in_data;
  logic       in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a_data;
  logic       a_valid;
  logic       a_ready;
  logic [3:0] b_data;
  logic       b_valid;
  logic       b_ready;
`ifdef DEMUX_CNT_EN
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;
`endif

  int tests_run;
  int tests_failed;

  demux_4_1_2_reg #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready)
`ifdef DEMUX_CNT_EN
    ,
    .cnt_a    (cnt_a),
    .cnt_b    (cnt_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
      else begin
        tests_failed++;
        $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  // Advance one clock and settle past the active edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    in_data  = 4'h0;
    in_sel   = 1'b0;
    in_valid = 1'b0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    tick();
    tick();
    check("rst_a_valid", 32'(a_valid), 32'd0);
    check("rst_b_valid", 32'(b_valid), 32'd0);
    check("rst_a_data", 32'(a_data), 32'd0);
    check("rst_b_data", 32'(b_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Route A then B, both consumers ready.
    a_ready = 1'b1; b_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 4'hA;
    #1 check("route_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("route_a_valid", 32'(a_valid), 32'd1);
    check("route_a_data", 32'(a_data), 32'hA);
    check("route_b_idle", 32'(b_valid), 32'd0);
    in_sel = 1'b1; in_data = 4'h5;
    tick();
    check("route_b_valid", 32'(b_valid), 32'd1);
    check("route_b_data", 32'(b_data), 32'h5);
    check("route_a_drained", 32'(a_valid), 32'd0);
    check("route_a_data_hold", 32'(a_data), 32'hA);
    in_valid = 1'b0;
    tick();
    check("route_b_drained", 32'(b_valid), 32'd0);

    // Backpressure on A: 3 held, 7 stalls, then replaces 3 on the draining edge.
    a_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h3;
    tick();
    check("bp_a_valid", 32'(a_valid), 32'd1);
    check("bp_a_data3", 32'(a_data), 32'h3);
    in_data = 4'h7;
    #1 check("bp_in_ready_low", 32'(in_ready), 32'd0);
    tick();
    check("bp_a_data_stable", 32'(a_data), 32'h3);
    a_ready = 1'b1;
    #1 check("bp_in_ready_high", 32'(in_ready), 32'd1);
    tick();
    check("bp_no_bubble_valid", 32'(a_valid), 32'd1);
    check("bp_no_bubble_data", 32'(a_data), 32'h7);
    in_valid = 1'b0;
    tick();
    check("bp_a_empty", 32'(a_valid), 32'd0);

    // Head-of-line: a stalled A word keeps a following B word from reaching B.
    a_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h9;
    tick();
    in_data = 4'h2;
    #1 check("hol_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("hol_b_idle1", 32'(b_valid), 32'd0);
    tick();
    check("hol_b_idle2", 32'(b_valid), 32'd0);
    check("hol_a_data", 32'(a_data), 32'h9);
    a_ready = 1'b1;
    tick();
    check("hol_a_data2", 32'(a_data), 32'h2);
    in_sel = 1'b1; in_data = 4'h6;
    tick();
    check("hol_b_valid", 32'(b_valid), 32'd1);
    check("hol_b_data", 32'(b_data), 32'h6);
    check("hol_a_empty", 32'(a_valid), 32'd0);
    in_valid = 1'b0;
    tick();

    // A full slot does not block a word aimed at the other slot.
    a_ready = 1'b0; b_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 4'hD;
    tick();
    in_sel = 1'b0; in_data = 4'hC;
    #1 check("indep_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("indep_a_data", 32'(a_data), 32'hC);
    check("indep_b_data", 32'(b_data), 32'hD);
    check("indep_both_valid", 32'({a_valid, b_valid}), 32'b11);

    // Flush with an accepted input: both slots empty, word dropped.
    a_ready = 1'b1;
    in_sel = 1'b0; in_data = 4'hE; flush = 1'b1;
    #1 check("flush_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("flush_valids", 32'({a_valid, b_valid}), 32'b00);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    check("flush_dropped", 32'({a_valid, b_valid}), 32'b00);

    // Asynchronous reset between edges.
    a_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 4'hB;
    tick();
    check("async_pre_data", 32'(a_data), 32'hB);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_a_valid", 32'(a_valid), 32'd0);
    check("async_a_data", 32'(a_data), 32'd0);
    check("async_b_valid", 32'(b_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

`ifdef DEMUX_CNT_EN
    check("cnt_reset_a", 32'(cnt_a), 32'd0);
    a_ready = 1'b1; b_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 4'h1;
    tick();
    in_valid = 1'b0;
    tick();
    check("cnt_b_one", 32'(cnt_b), 32'd1);
    in_valid = 1'b1; in_sel = 1'b0;
    for (int i = 0; i < 256; i++) begin
      in_data = 4'(i);
      tick();
    end
    check("cnt_a_255", 32'(cnt_a), 32'd255);
    in_valid = 1'b0;
    tick();
    check("cnt_a_wrap", 32'(cnt_a), 32'd0);
    check("cnt_b_unchanged", 32'(cnt_b), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
